// File: rtl/sevenseg_scan_controller.sv
// Time-multiplexed 7-segment scan controller: per-digit hex registers, prescaled
// digit slots with a one-cycle blank between digits. Optional macro: LEADING_ZERO_BLANK_EN.
module sevenseg_scan_controller #(
  parameter int NUM_DIGITS = 8,
  parameter int DIV        = 100000,
  parameter int DIV_W      = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  wr_en,
  input  logic [2:0]            wr_addr,
  input  logic [3:0]            wr_data,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic [NUM_DIGITS-1:0] digit_mask,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            sseg,
  output logic                  dp,
  output logic                  frame_done
);

  // state      | meaning
  // ST_BLANK   | all segments and anodes off for one slot cycle (anti-ghosting)
  // ST_DISPLAY | digit sel driven for the remaining DIV-1 cycles of the slot

  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {
    ST_BLANK   = 1'b0,
    ST_DISPLAY = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [SEL_W-1:0]        sel, sel_nxt;
  logic [DIV_W-1:0]        count, count_nxt;
  logic [3:0]              digit_q [NUM_DIGITS];
  logic                    tick;
  logic                    last_digit;
  logic [NUM_DIGITS-1:0]   dark;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic [6:0]              sseg_nxt;
  logic                    dp_nxt;
  logic                    frame_done_nxt;

  function automatic logic [6:0] hex_to_sseg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick       = (count == DIV_W'(DIV - 1));
  assign last_digit = (sel == SEL_W'(NUM_DIGITS - 1));

`ifdef LEADING_ZERO_BLANK_EN
  // A zero digit is dark only when every more significant digit is also zero.
  always_comb begin
    logic higher_nz;
    higher_nz = 1'b0;
    dark      = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      dark[i]   = ~higher_nz & (digit_q[i] == 4'd0);
      higher_nz = higher_nz | (digit_q[i] != 4'd0);
    end
  end
`else
  assign dark = '0;
`endif

  always_comb begin
    state_nxt      = state;
    sel_nxt        = sel;
    count_nxt      = tick ? '0 : count + DIV_W'(1);
    an_nxt         = '1;
    sseg_nxt       = 7'h7F;
    dp_nxt         = 1'b1;
    frame_done_nxt = 1'b0;
    case (state)
      ST_BLANK: state_nxt = ST_DISPLAY;
      ST_DISPLAY: begin
        if (!dark[sel]) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            an_nxt[i] = !(digit_mask[i] && (sel == SEL_W'(i)));
          end
          sseg_nxt = hex_to_sseg(digit_q[sel]);
          dp_nxt   = ~dp_in[sel];
        end
        if (tick) begin
          state_nxt      = ST_BLANK;
          sel_nxt        = last_digit ? '0 : sel + SEL_W'(1);
          frame_done_nxt = last_digit;
        end
      end
      default: state_nxt = ST_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_BLANK;
      sel        <= '0;
      count      <= '0;
      an         <= '1;
      sseg       <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else if (enable) begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      count      <= count_nxt;
      an         <= an_nxt;
      sseg       <= sseg_nxt;
      dp         <= dp_nxt;
      frame_done <= frame_done_nxt;
    end else begin
      frame_done <= 1'b0;
    end
  end

  // Digit registers take writes regardless of enable so values can be staged while frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= 4'd0;
    end else if (wr_en && (int'(wr_addr) < NUM_DIGITS)) begin
      digit_q[wr_addr[SEL_W-1:0]] <= wr_data;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_controller.sv
// Scoreboard bench for sevenseg_scan_controller (4 digits, 4 cycles per slot).
module tb_sevenseg_scan_controller;

  localparam int N   = 4;
  localparam int DIV = 4;

  logic         clk = 1'b0;
  logic         reset, enable, wr_en;
  logic [2:0]   wr_addr;
  logic [3:0]   wr_data;
  logic [N-1:0] dp_in, digit_mask;
  logic [N-1:0] an;
  logic [6:0]   sseg;
  logic         dp, frame_done;

  sevenseg_scan_controller #(.NUM_DIGITS(N), .DIV(DIV), .DIV_W(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .dp_in(dp_in), .digit_mask(digit_mask), .an(an),
    .sseg(sseg), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] an;
    logic [6:0]   sseg;
    logic         dp;
    logic         fd;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       last_exp;
  logic [6:0] hex_lut [16];
  logic [3:0] m_dig [N];
  int         k;
  int         cyc;
  int         n_checks;
  int         n_err;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic exp_t model_out(input int kk);
    exp_t e;
    int   ph, d;
    logic dark;
    ph   = kk % DIV;
    d    = (kk / DIV) % N;
    e.an = '1; e.sseg = 7'h7F; e.dp = 1'b1;
    e.fd = ((kk % (DIV * N)) == DIV * N - 1);
    dark = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0) begin
      dark = 1'b1;
      for (int j = d; j < N; j++) if (m_dig[j] != 4'd0) dark = 1'b0;
    end
`endif
    if (ph != 0 && !dark) begin
      e.an   = digit_mask[d] ? ~(4'b0001 << d) : 4'hF;
      e.sseg = hex_lut[m_dig[d]];
      e.dp   = ~dp_in[d];
    end
    return e;
  endfunction

  task automatic step();
    exp_t e, got;
    if (reset) e = '{an: '1, sseg: 7'h7F, dp: 1'b1, fd: 1'b0};
    else if (enable) e = model_out(k);
    else begin e = last_exp; e.fd = 1'b0; end
    exp_q.push_back(e);
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < N; i++) m_dig[i] = 4'd0;
      k = 0;
    end else begin
      if (wr_en && wr_addr < 3'(N)) m_dig[wr_addr[1:0]] = wr_data;
      if (enable) k++;
    end
    last_exp = e;
    #1;
    cyc++;
    got = exp_q.pop_front();
    check_val("an", 8'(an), 8'(got.an));
    check_val("sseg", 8'(sseg), 8'(got.sseg));
    check_val("dp", 8'(dp), 8'(got.dp));
    check_val("frame_done", 8'(frame_done), 8'(got.fd));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write_digit(input logic [2:0] a, input logic [3:0] v);
    wr_en = 1'b1; wr_addr = a; wr_data = v;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    hex_lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    for (int i = 0; i < N; i++) m_dig[i] = 4'd0;
    k = 0; cyc = 0; n_checks = 0; n_err = 0;
    last_exp = '{an: '1, sseg: 7'h7F, dp: 1'b1, fd: 1'b0};
    reset = 1'b1; enable = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    dp_in = '0; digit_mask = '1;

    run(2);
    reset = 1'b0; enable = 1'b1;
    run(20);

    write_digit(3'd3, 4'hF);
    write_digit(3'd2, 4'hA);
    write_digit(3'd1, 4'h9);
    write_digit(3'd0, 4'h0);
    run(32);

    digit_mask = 4'b1010; dp_in = 4'b0101;
    run(32);
    digit_mask = 4'hF;

    // Freeze mid-DISPLAY, stage writes (one out of range) while frozen.
    for (int i = 0; i < 16 && (k % DIV) != 2; i++) step();
    enable = 1'b0;
    step();
    write_digit(3'd1, 4'h5);
    write_digit(3'd5, 4'h7);
    run(2);
    enable = 1'b1;
    run(24);

    // Reset in the middle of digit 2's slot.
    for (int i = 0; i < 16 && !((k / DIV) % N == 2 && (k % DIV) == 2); i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    run(20);

    write_digit(3'd2, 4'h5);
    dp_in = 4'b1000;
    run(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
